// File: rtl/quad_step_decoder.sv
// quad_step_decoder: front end for the 2-bit up/down counter stage.
// Synchronises and debounces two raw quadrature channels, decodes Gray-code
// steps into a one-cycle en strobe with a dir level, and raises a sticky err
// when both filtered channels change on the same edge.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       clr_err,
    output logic       en,
    output logic       dir,
    output logic       err,
    output logic       ready,
    output logic [1:0] ab
);

    localparam int DB_W   = $clog2(DB_CYCLES) + 1;
    localparam int INIT_W = $clog2(SYNC_STAGES + 1) + 1;

    // Last counter value before a filter accepts the new level.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    // Edge count (minus one) on which initialisation completes.
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             synced;
    logic [1:0]             filt;
    logic [1:0][DB_W-1:0]   db_cnt;
    logic [1:0]             prev;
    logic [INIT_W-1:0]      init_cnt;
    logic [1:0]             fwd_next;
    logic [1:0]             rev_next;
    logic                   step_fwd;
    logic                   step_rev;
    logic                   step_bad;

    // Bit 1 of every pair is channel A, bit 0 is channel B.
    assign synced = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign ab     = filt;

    // Plain flop chains bring the asynchronous inputs into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a_in};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b_in};
        end
    end

    // Count the start-up edges so the filters can be preloaded before decoding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt <= '0;
            ready    <= 1'b0;
        end else if (!ready) begin
            if (init_cnt == INIT_LAST) begin
                ready <= 1'b1;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Per-channel filter: accept a new level only after DB_CYCLES steady samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt   <= '0;
            db_cnt <= '0;
        end else if (!ready) begin
            filt   <= synced;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (synced[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= synced[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Successor of the previous pair in each rotation direction of the Gray cycle.
    always_comb begin
        fwd_next = 2'b00;
        rev_next = 2'b00;
        case (prev)
            2'b00: begin fwd_next = 2'b10; rev_next = 2'b01; end
            2'b10: begin fwd_next = 2'b11; rev_next = 2'b00; end
            2'b11: begin fwd_next = 2'b01; rev_next = 2'b10; end
            2'b01: begin fwd_next = 2'b00; rev_next = 2'b11; end
            default: begin fwd_next = 2'b00; rev_next = 2'b00; end
        endcase
    end

    // Classify the movement from the previous pair to the current filtered pair.
    always_comb begin
        step_fwd = ready && (filt == fwd_next);
        step_rev = ready && (filt == rev_next);
        step_bad = ready && (filt == ~prev);
    end

    // The previous pair follows the synchroniser at start-up, then the filters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else if (!ready) begin
            prev <= synced;
        end else begin
            prev <= filt;
        end
    end

    // Registered step strobe, held direction and sticky error (set beats clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en  <= 1'b0;
            dir <= 1'b0;
            err <= 1'b0;
        end else begin
            en <= step_fwd | step_rev;
            if (step_fwd | step_rev) begin
                dir <= step_fwd;
            end
            if (step_bad) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed scenarios followed by random input activity,
// with a behavioural model (delay queues, sample windows and Gray positions)
// compared against the decoder on every falling clock edge.
module tb_quad_step_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       a_in    = 1'b0;
    logic       b_in    = 1'b0;
    logic       clr_err = 1'b0;
    logic       en;
    logic       dir;
    logic       err;
    logic       ready;
    logic [1:0] ab;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int up_seen   = 0;
    int dn_seen   = 0;
    bit chk_on    = 1'b0;

    // Model state
    bit       m_en;
    bit       m_dir;
    bit       m_err;
    bit       m_ready;
    bit [1:0] m_ab;
    bit [1:0] m_prev;
    int       m_edges;
    bit       qa[$];
    bit       qb[$];
    bit       wa[$];
    bit       wb[$];

    quad_step_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CYCLES  (DB_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a_in   (a_in),
        .b_in   (b_in),
        .clr_err(clr_err),
        .en     (en),
        .dir    (dir),
        .err    (err),
        .ready  (ready),
        .ab     (ab)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit a, input bit b, input int hold);
        a_in = a;
        b_in = b;
        tick(hold);
    endtask

    // Position of a pair on the Gray cycle 00 -> 10 -> 11 -> 01.
    function automatic int gray_pos(input bit [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_en    = 1'b0;
        m_dir   = 1'b0;
        m_err   = 1'b0;
        m_ready = 1'b0;
        m_ab    = 2'b00;
        m_prev  = 2'b00;
        m_edges = 0;
        qa.delete();
        qb.delete();
        wa.delete();
        wb.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            qa.push_back(1'b0);
            qb.push_back(1'b0);
        end
    endtask

    task automatic model_step();
        bit sa;
        bit sb;
        bit acc_a;
        bit acc_b;
        int delta;
        sa = qa.pop_front();
        sb = qb.pop_front();
        qa.push_back(a_in);
        qb.push_back(b_in);
        m_edges++;
        if (m_edges <= SYNC_STAGES + 1) begin
            m_ab   = {sa, sb};
            m_prev = {sa, sb};
            m_en   = 1'b0;
            if (m_edges == SYNC_STAGES + 1) m_ready = 1'b1;
            wa.delete();
            wb.delete();
        end else begin
            delta = (gray_pos(m_ab) - gray_pos(m_prev) + 4) % 4;
            m_en  = (delta == 1) || (delta == 3);
            if (m_en) m_dir = (delta == 1);
            if (delta == 2) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
            m_prev = m_ab;
            wa.push_back(sa);
            wb.push_back(sb);
            if (wa.size() > DB_CYCLES) void'(wa.pop_front());
            if (wb.size() > DB_CYCLES) void'(wb.pop_front());
            acc_a = (wa.size() == DB_CYCLES);
            acc_b = (wb.size() == DB_CYCLES);
            foreach (wa[i]) if (wa[i] == m_ab[1]) acc_a = 1'b0;
            foreach (wb[i]) if (wb[i] == m_ab[0]) acc_b = 1'b0;
            if (acc_a) m_ab[1] = sa;
            if (acc_b) m_ab[0] = sb;
        end
    endtask

    // Reference model advances on every clock edge and resets asynchronously.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Compare process: DUT against model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                checkOutput("en", 32'(en), 32'(m_en));
                checkOutput("dir", 32'(dir), 32'(m_dir));
                checkOutput("err", 32'(err), 32'(m_err));
                checkOutput("ready", 32'(ready), 32'(m_ready));
                checkOutput("ab", 32'(ab), 32'(m_ab));
                if (en === 1'b1) begin
                    if (dir === 1'b1) up_seen++;
                    else dn_seen++;
                end
            end
        end
    end

    initial begin
        int u0;
        int d0;

        // Reset release with both inputs high
        #1;
        rst  = 1'b0;
        a_in = 1'b1;
        b_in = 1'b1;
        chk_on = 1'b1;
        #1;
        checkOutput("rst_en", 32'(en), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_ab", 32'(ab), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(2);
        checkOutput("init_ready_early", 32'(ready), 32'd0);
        tick(1);
        checkOutput("init_ready", 32'(ready), 32'd1);
        checkOutput("init_ab", 32'(ab), 32'h3);
        checkOutput("init_err", 32'(err), 32'd0);
        checkOutput("init_no_step", 32'(up_seen + dn_seen), 32'd0);

        // Re-initialise at 00 for the forward cycle
        tick(1);
        rst  = 1'b0;
        a_in = 1'b0;
        b_in = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(5);
        checkOutput("reinit_ab", 32'(ab), 32'h0);

        // Clean forward cycle with latency pinned on the first step
        u0 = up_seen;
        d0 = dn_seen;
        a_in = 1'b1;
        tick(6);
        checkOutput("lat_en_early", 32'(en), 32'd0);
        tick(1);
        checkOutput("lat_en", 32'(en), 32'd1);
        checkOutput("lat_dir", 32'(dir), 32'd1);
        tick(3);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("fwd_up", 32'(up_seen - u0), 32'd4);
        checkOutput("fwd_dn", 32'(dn_seen - d0), 32'd0);

        // Reverse steps then a reversal
        u0 = up_seen;
        d0 = dn_seen;
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("rev_dn", 32'(dn_seen - d0), 32'd2);
        checkOutput("rev_up", 32'(up_seen - u0), 32'd1);
        checkOutput("rev_ab", 32'(ab), 32'h1);
        applyStimulus(1'b0, 1'b0, 10);

        // Glitch rejection and the shortest accepted pulse
        u0 = up_seen;
        d0 = dn_seen;
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("glitch_steps", 32'(up_seen + dn_seen - u0 - d0), 32'd0);
        checkOutput("glitch_ab", 32'(ab), 32'h0);
        applyStimulus(1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("pulse_up", 32'(up_seen - u0), 32'd1);
        checkOutput("pulse_dn", 32'(dn_seen - d0), 32'd1);

        // Illegal double transition, clear, and set-beats-clear
        u0 = up_seen;
        d0 = dn_seen;
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput("ill_err", 32'(err), 32'd1);
        checkOutput("ill_ab", 32'(ab), 32'h3);
        checkOutput("ill_dir", 32'(dir), 32'd0);
        checkOutput("ill_steps", 32'(up_seen + dn_seen - u0 - d0), 32'd0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("clr_err", 32'(err), 32'd0);
        clr_err = 1'b1;
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("setclr_before", 32'(err), 32'd0);
        tick(1);
        checkOutput("setclr_wins", 32'(err), 32'd1);
        tick(1);
        checkOutput("setclr_after", 32'(err), 32'd0);
        clr_err = 1'b0;
        tick(5);

        // Reset while a step is inside the debounce window
        a_in = 1'b1;
        tick(4);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_en", 32'(en), 32'd0);
        checkOutput("mid_err", 32'(err), 32'd0);
        checkOutput("mid_ready", 32'(ready), 32'd0);
        checkOutput("mid_ab", 32'(ab), 32'h0);
        tick(2);
        u0 = up_seen;
        d0 = dn_seen;
        rst = 1'b1;
        tick(20);
        checkOutput("mid_no_step", 32'(up_seen + dn_seen - u0 - d0), 32'd0);
        checkOutput("mid_ab_after", 32'(ab), 32'h2);
        checkOutput("mid_ready_after", 32'(ready), 32'd1);

        // Random activity against the model
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst = 1'b0;
                tick(2);
                rst = 1'b1;
            end
            clr_err = ($urandom_range(0, 7) == 0);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 12)));
        end
        clr_err = 1'b0;
        tick(20);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
